bit32_mux_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the 32-bit 2:1 mux datapath.

---
 rtl/bit32_mux_arbiter.sv | 155 +++++++++++++++
 tb/tb_bit32_mux_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit32_mux_arbiter.sv
// rtl/bit32_mux_arbiter.sv - two-source round-robin packet arbiter driving a registered 32-bit 2:1 mux
// Optional feature macro: MUX_ARB_STATS_EN adds saturating per-source grant counters.
module bit32_mux_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
`ifdef MUX_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_last,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] grant2_cnt
`endif
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN1 = 2'd1,
        S_OWN2 = 2'd2
    } state_t;

    state_t           state_q;
    logic             sel_q;
    logic             busy_q;
    logic             prio_q;
    logic [BW-1:0]    beat_cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;

    logic             ld;
    logic             acc;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             other_valid;
    logic             burst_hit;
    logic             rel;
    logic             go1;
    logic             go2;
    logic             go_idle;

    // Ready follows out_ready combinationally so a draining output can refill every cycle.
    always_comb begin
        ld          = !out_valid_q || out_ready;
        in1_ready   = (state_q == S_OWN1) && ld;
        in2_ready   = (state_q == S_OWN2) && ld;
        acc         = (in1_valid && in1_ready) || (in2_valid && in2_ready);
        cur_last    = sel_q ? in2_last : in1_last;
        cur_data    = sel_q ? in2_data : in1_data;
        other_valid = sel_q ? in1_valid : in2_valid;
        burst_hit   = (beat_cnt_q == BW'(MAX_BURST - 1));
        rel         = acc && (cur_last || (burst_hit && other_valid));
        go1 = ((state_q == S_IDLE) && in1_valid && (!in2_valid || !prio_q)) ||
              ((state_q == S_OWN2) && rel && in1_valid);
        go2 = ((state_q == S_IDLE) && in2_valid && (!in1_valid || prio_q)) ||
              ((state_q == S_OWN1) && rel && in2_valid);
        go_idle = rel && !other_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
            prio_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (rel) begin
                prio_q <= !sel_q;
            end
            if (go1) begin
                state_q    <= S_OWN1;
                sel_q      <= 1'b0;
                busy_q     <= 1'b1;
                beat_cnt_q <= '0;
            end else if (go2) begin
                state_q    <= S_OWN2;
                sel_q      <= 1'b1;
                busy_q     <= 1'b1;
                beat_cnt_q <= '0;
            end else if (go_idle) begin
                state_q    <= S_IDLE;
                sel_q      <= 1'b0;
                busy_q     <= 1'b0;
                beat_cnt_q <= '0;
            end else if (acc && !burst_hit) begin
                // A burst-limit hit with the other side idle keeps the grant and pins the count.
                beat_cnt_q <= beat_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (ld) begin
            out_valid_q <= acc;
            if (acc) begin
                out_data_q <= cur_data;
                out_last_q <= cur_last;
            end
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] grant1_cnt_q;
    logic [CNT_W-1:0] grant2_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant1_cnt_q <= '0;
            grant2_cnt_q <= '0;
        end else begin
            if (go1 && !(&grant1_cnt_q)) begin
                grant1_cnt_q <= grant1_cnt_q + CNT_W'(1);
            end
            if (go2 && !(&grant2_cnt_q)) begin
                grant2_cnt_q <= grant2_cnt_q + CNT_W'(1);
            end
        end
    end

    assign grant1_cnt = grant1_cnt_q;
    assign grant2_cnt = grant2_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bit32_mux_arbiter.sv
// tb/tb_bit32_mux_arbiter.sv - self-checking bench for bit32_mux_arbiter
module tb_bit32_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in1_valid, in1_last, in1_ready;
    logic [31:0] in1_data;
    logic        in2_valid, in2_last, in2_ready;
    logic [31:0] in2_data;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic        sel, busy;
`ifdef MUX_ARB_STATS_EN
    logic [15:0] grant1_cnt, grant2_cnt;
`endif

    always #5 clk = ~clk;

    bit32_mux_arbiter dut (
        .clk(clk), .reset(reset),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .busy(busy)
`ifdef MUX_ARB_STATS_EN
        , .grant1_cnt(grant1_cnt), .grant2_cnt(grant2_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic v1, v2;
        logic busy, sel, r1, r2;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    abort = 0;
    beat_t sb[$];
    int    acc_src[$];
    int    acc_cyc[$];
    logic  prev_acc = 1'b0;
    beat_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: accepted beats are pushed, output handshakes pop and compare.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) chk("valid_latency", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
            end
            prev_acc = 1'b0;
            if (in1_valid && in1_ready) begin
                sb.push_back('{in1_data, in1_last});
                acc_src.push_back(1);
                acc_cyc.push_back(cyc);
                chk("sel_at_acc1", sel, 0);
                prev_acc = 1'b1;
            end
            if (in2_valid && in2_ready) begin
                sb.push_back('{in2_data, in2_last});
                acc_src.push_back(2);
                acc_cyc.push_back(cyc);
                chk("sel_at_acc2", sel, 1);
                chk("single_grant", in1_valid && in1_ready, 0);
                prev_acc = 1'b1;
            end
        end
    end

    function automatic logic fired(input int s);
        return (s == 1) ? (in1_valid && in1_ready) : (in2_valid && in2_ready);
    endfunction

    task automatic put(input int s, input logic v, input logic [31:0] d, input logic l);
        if (s == 1) begin
            in1_valid = v; in1_data = d; in1_last = l;
        end else begin
            in2_valid = v; in2_data = d; in2_last = l;
        end
    endtask

    task automatic drive(input int s, input int n, input logic [31:0] base);
        int t;
        for (int i = 0; i < n; i++) begin
            put(s, 1'b1, base + 32'(i), (i == n - 1));
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!fired(s) && t < 100 && !abort);
            if (abort) break;
            chk($sformatf("accept_src%0d", s), fired(s), 1);
            if (!fired(s)) break;
            @(posedge clk);
            #1;
        end
        put(s, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in1_valid = 0; in1_data = 0; in1_last = 0;
        in2_valid = 0; in2_data = 0; in2_last = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        acc_src.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_acc(input int n);
        int t;
        t = 0;
        while (acc_src.size() < n && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("wait_acc", acc_src.size() >= n, 1);
    endtask

    vec_t vt[4];
    int   exp3[5];
    int   exp4[11];
    int   start;

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp3 = '{1, 1, 1, 2, 2};
        exp4 = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_in2_ready", in2_ready, 0);

        // Arbitration table from a freshly reset arbiter
        for (int i = 0; i < 4; i++) begin
            do_reset();
            out_ready = 1'b1;
            put(1, vt[i].v1, 32'hA100_0000 + 32'(i), 1'b1);
            put(2, vt[i].v2, 32'hA200_0000 + 32'(i), 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_bubble_r1", i), in1_ready, 0);
            chk($sformatf("vec%0d_bubble_r2", i), in2_ready, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_sel", i), sel, vt[i].sel);
            chk($sformatf("vec%0d_r1", i), in1_ready, vt[i].r1);
            chk($sformatf("vec%0d_r2", i), in2_ready, vt[i].r2);
            @(posedge clk);
            #1;
            put(1, 1'b0, 32'h0, 1'b0);
            put(2, 1'b0, 32'h0, 1'b0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Single 3-beat packet from in1
        do_reset();
        out_ready = 1'b1;
        start = cyc;
        drive(1, 3, 32'hA0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_beats", acc_src.size(), 3);
        chk("t2_first_latency", acc_cyc[0] - start, 1);
        chk("t2_busy_end", busy, 0);
        chk("t2_sel_end", sel, 0);
        chk("t2_sb_drained", sb.size(), 0);

        // Simultaneous requests: in1 first, then straight into OWN2
        do_reset();
        out_ready = 1'b1;
        fork
            drive(1, 3, 32'hB0);
            drive(2, 2, 32'hC0);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t3_beats", acc_src.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), acc_src[i], exp3[i]);
        chk("t3_no_idle_gap", acc_cyc[3] - acc_cyc[2], 1);
        chk("t3_sb_drained", sb.size(), 0);

        // Burst limit: 8 in1 beats then forced handover to in2
        do_reset();
        out_ready = 1'b1;
        fork
            drive(1, 10, 32'hD0);
            drive(2, 1, 32'hE0);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t4_beats", acc_src.size(), 11);
        for (int i = 0; i < 11; i++) chk($sformatf("t4_order%0d", i), acc_src[i], exp4[i]);
        chk("t4_handover_gap", acc_cyc[8] - acc_cyc[7], 1);
        chk("t4_return_gap", acc_cyc[9] - acc_cyc[8], 1);
        chk("t4_sb_drained", sb.size(), 0);

        // Backpressure hold for 4 cycles
        do_reset();
        out_ready = 1'b1;
        fork
            drive(1, 6, 32'hF0);
            begin
                wait_acc(2);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t5_hold_valid", out_valid, 1);
                    chk("t5_hold_data", out_data, 32'hF1);
                    chk("t5_hold_r1", in1_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t5_beats", acc_src.size(), 6);
        chk("t5_sb_drained", sb.size(), 0);

        // Reset in the middle of an in2 packet
        do_reset();
        out_ready = 1'b1;
        fork
            drive(2, 5, 32'h60);
            begin
                wait_acc(2);
                @(posedge clk);
                #1;
                reset = 1'b1;
                abort = 1'b1;
                in2_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("t6_out_valid", out_valid, 0);
                chk("t6_busy", busy, 0);
                chk("t6_sel", sel, 0);
`ifdef MUX_ARB_STATS_EN
                chk("t6_grant1_cnt", grant1_cnt, 0);
                chk("t6_grant2_cnt", grant2_cnt, 0);
`endif
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        abort = 1'b0;
        in2_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_stays_idle", busy, 0);
        chk("t6_no_output", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
